// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_unit (optional counters: FETCH_PERF_CNT_EN) and fetch_skid_buffer.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic logic [XLEN_DEFAULT-1:0] next_fetch_pc(input logic [XLEN_DEFAULT-1:0] pc);
    return pc + XLEN_DEFAULT'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched PC/instruction pairs ahead of decode.
// Flush wins over push and pop; pop of an empty buffer is ignored.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         head_valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   free_cnt_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count_q says so.
  always_ff @(posedge clock) begin
    if (!reset && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_valid_o = (count_q != 2'd0);
  assign head_o       = mem_q[rd_ptr_q];
  assign free_cnt_o   = 2'd2 - count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to the I-cache,
// buffers responses for decode. Define FETCH_PERF_CNT_EN for perf counter outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic            ic_req_valid,
  input  logic            ic_req_ready,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_resp_valid,
  input  logic [XLEN-1:0] ic_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;

  logic            buf_push;
  logic            buf_pop;
  logic            buf_flush;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [1:0]      free_cnt;
  logic            req_fire;

  fetch_skid_buffer u_skid (
    .clock        (clock),
    .reset        (reset),
    .push_i       (buf_push),
    .push_entry_i (push_entry),
    .pop_i        (buf_pop),
    .flush_i      (buf_flush),
    .head_valid_o (head_valid),
    .head_o       (head),
    .free_cnt_o   (free_cnt)
  );

  // A slot freed by this cycle's pop counts, so a full buffer can keep streaming.
  always_comb begin
    if_valid     = head_valid && !reset;
    if_pc        = reset ? '0 : head.pc;
    if_instr     = reset ? '0 : head.instr;
    buf_pop      = if_valid && if_ready;
    ic_req_valid = !reset && (state_q == FETCH) && ((free_cnt != 2'd0) || buf_pop);
    ic_req_addr  = pc_q;
    req_fire     = ic_req_valid && ic_req_ready;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    buf_push   = 1'b0;
    buf_flush  = 1'b0;
    push_entry = '{pc: pc_q, instr: ic_resp_data};

    if (redirect_valid) begin
      pc_d      = redirect_pc & ALIGN_MASK;
      buf_flush = 1'b1;
      if (state_q == WAIT) begin
        if (ic_resp_valid) begin
          state_d = FETCH;
          drop_d  = 1'b0;
        end else begin
          state_d = WAIT;
          drop_d  = 1'b1;
        end
      end else if (req_fire) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = FETCH;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (req_fire) state_d = WAIT;
        end
        WAIT: begin
          if (ic_resp_valid) begin
            state_d = FETCH;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              buf_push = 1'b1;
              pc_d     = next_fetch_pc(pc_q);
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Saturating counters; redirects deliberately leave them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (buf_pop && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (if_valid && !if_ready && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural I-cache model plus a scoreboard
// of expected PC/instruction pairs popped on every decode handshake.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req_valid;
  logic        ic_req_ready = 1'b1;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid = 1'b0;
  logic [31:0] ic_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  int          checks = 0;
  int          errors = 0;
  expEntry_t   expQ[$];
  logic [31:0] reqLog[$];
  int          popCount = 0;
  int          cacheLat = 1;
  bit          pending = 1'b0;
  int          pendCnt = 0;
  logic [31:0] pendAddr = '0;
  logic [31:0] pendSalt = '0;
  logic [31:0] salt = '0;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] instrFor(input logic [31:0] addr, input logic [31:0] s);
    return addr ^ 32'hDEAD_BEEF ^ s;
  endfunction

  function automatic logic [31:0] logAt(input int idx);
    if (reqLog.size() > idx) return reqLog[idx];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ifRdy, input logic reqRdy,
                               input logic redir, input logic [31:0] redirPc);
    reset          = rst;
    if_ready       = ifRdy;
    ic_req_ready   = reqRdy;
    redirect_valid = redir;
    redirect_pc    = redirPc;
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
    expEntry_t e;
    e.pc    = pc;
    e.instr = instr;
    expQ.push_back(e);
  endtask

  // One clock: sample handshakes at negedge, then advance the cache model after posedge.
  task automatic tick();
    logic        acc;
    logic [31:0] accAddr;
    logic        popped;
    logic [31:0] pPc;
    logic [31:0] pInstr;
    logic        respNow;
    expEntry_t   e;
    @(negedge clock);
    acc     = ic_req_valid && ic_req_ready;
    accAddr = ic_req_addr;
    popped  = if_valid && if_ready;
    pPc     = if_pc;
    pInstr  = if_instr;
    respNow = ic_resp_valid;
    @(posedge clock);
    #1;
    if (respNow) ic_resp_valid = 1'b0;
    if (acc) begin
      reqLog.push_back(accAddr);
      pending  = 1'b1;
      pendCnt  = cacheLat - 1;
      pendAddr = accAddr;
      pendSalt = salt;
    end
    if (pending) begin
      if (pendCnt == 0) begin
        ic_resp_valid = 1'b1;
        ic_resp_data  = instrFor(pendAddr, pendSalt);
        pending       = 1'b0;
      end else begin
        pendCnt--;
      end
    end
    if (popped) begin
      popCount++;
      checkOutput("sb_nonempty", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_pc", pPc, e.pc);
        checkOutput("sb_instr", pInstr, e.instr);
      end
    end
    #1;
  endtask

  task automatic resetDut();
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    pending       = 1'b0;
    ic_resp_valid = 1'b0;
    cacheLat      = 1;
    salt          = '0;
    popCount      = 0;
    expQ.delete();
    reqLog.delete();
    #1;
    checkOutput("rst_req_valid", 32'(ic_req_valid), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
  endtask

  task automatic runUntilPops(input int n, input int budget);
    int c = 0;
    while (popCount < n && c < budget) begin
      tick();
      c++;
    end
    checkOutput("pop_count", 32'(popCount), 32'(n));
  endtask

  initial begin
    // Streaming with a 1-cycle cache and decode always ready.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_first_req_valid", 32'(ic_req_valid), 32'd1);
    checkOutput("s1_first_req_addr", ic_req_addr, 32'h0000_1000);
    pushExp(32'h1000, instrFor(32'h1000, 0));
    pushExp(32'h1004, instrFor(32'h1004, 0));
    pushExp(32'h1008, instrFor(32'h1008, 0));
    tick();
    checkOutput("s1_wait_req_valid", 32'(ic_req_valid), 32'd0);
    checkOutput("s1_no_comb_if_valid", 32'(if_valid), 32'd0);
    tick();
    checkOutput("s1_head_valid", 32'(if_valid), 32'd1);
    checkOutput("s1_head_pc", if_pc, 32'h1000);
    checkOutput("s1_next_req_addr", ic_req_addr, 32'h1004);
    runUntilPops(3, 30);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_log0", logAt(0), 32'h1000);
    checkOutput("s1_log1", logAt(1), 32'h1004);
    checkOutput("s1_log2", logAt(2), 32'h1008);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("s1_perf_fetched", perf_fetched, 32'd3);
`endif

    // Decode stalled: buffer fills with two entries, then drains in order.
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 3) checkOutput("s2_stall_pc_stable", if_pc, 32'h1000);
    end
    checkOutput("s2_full_req_valid", 32'(ic_req_valid), 32'd0);
    checkOutput("s2_full_if_valid", 32'(if_valid), 32'd1);
    checkOutput("s2_req_count", 32'(reqLog.size()), 32'd2);
    pushExp(32'h1000, instrFor(32'h1000, 0));
    pushExp(32'h1004, instrFor(32'h1004, 0));
    pushExp(32'h1008, instrFor(32'h1008, 0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_release_req_valid", 32'(ic_req_valid), 32'd1);
    checkOutput("s2_release_req_addr", ic_req_addr, 32'h1008);
    runUntilPops(3, 30);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect while waiting on a slow response: that response must be dropped.
    resetDut();
    cacheLat = 3;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pushExp(32'h2000, instrFor(32'h2000, 0));
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h2002);
    checkOutput("s3_wait_req_valid", 32'(ic_req_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    runUntilPops(1, 30);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s3_redirect_req", logAt(1), 32'h2000);

    // Redirect in the same cycle as the response.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pushExp(32'h2000, instrFor(32'h2000, 0));
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s4_if_valid_flushed", 32'(if_valid), 32'd0);
    checkOutput("s4_req_valid", 32'(ic_req_valid), 32'd1);
    checkOutput("s4_req_addr", ic_req_addr, 32'h2000);
    runUntilPops(1, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Cache back-pressure: request held stable.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("s5_hold_valid", 32'(ic_req_valid), 32'd1);
      checkOutput("s5_hold_addr", ic_req_addr, 32'h1000);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pushExp(32'h1000, instrFor(32'h1000, 0));
    runUntilPops(1, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_log0", logAt(0), 32'h1000);

    // PC wrap at the top of the address space.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s6_req_addr", ic_req_addr, 32'hFFFF_FFFC);
    pushExp(32'hFFFF_FFFC, instrFor(32'hFFFF_FFFC, 0));
    pushExp(32'h0000_0000, instrFor(32'h0000_0000, 0));
    runUntilPops(2, 30);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s6_log0", logAt(0), 32'hFFFF_FFFC);
    checkOutput("s6_log1", logAt(1), 32'h0000_0000);

    // Reset while waiting: the late response must be ignored.
    resetDut();
    cacheLat = 3;
    salt     = 32'h1111_0000;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s7_post_reset_valid", 32'(ic_req_valid), 32'd1);
    checkOutput("s7_post_reset_addr", ic_req_addr, 32'h1000);
    tick();
    tick();
    salt     = '0;
    cacheLat = 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s7_late_resp_ignored", 32'(if_valid), 32'd0);
    pushExp(32'h1000, instrFor(32'h1000, 0));
    runUntilPops(1, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s7_refetch_addr", logAt(1), 32'h1000);

    resetDut();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
